bsr_block_scheduler: RTL and testbench

- Sequences the sparse systolic array across a stream of block descriptors: one descriptor per K-block, each flagged zero or non-zero.
- For each non-zero block it loads weights row by row, then streams activations. Zero blocks are skipped with no array activity.
- After the last block it drains the array pipeline, then pulses done.
- Sits between the metadata/BSR decoder and the array plus its act/wgt buffers. Drives the array's load_weight and block_valid inputs.

---
 rtl/bsr_block_scheduler.sv | 173 +++++++++++++++++
 tb/tb_bsr_block_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_block_scheduler.sv
// Block-sparse scheduler: walks K-block descriptors, loads weights and streams activations for
// non-zero blocks, skips zero blocks, then drains the array and pulses done.
module bsr_block_scheduler #(
   parameter int unsigned N_ROWS = 14,
   parameter int unsigned N_COLS = 14,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [CNT_W-1:0]          cfg_stream_len_i,
   input  logic                      meta_valid_i,
   output logic                      meta_ready_o,
   input  logic                      meta_zero_i,
   input  logic                      meta_last_i,
   output logic                      wgt_rd_en_o,
   output logic [$clog2(N_ROWS)-1:0] wgt_rd_row_o,
   output logic                      act_rd_en_o,
   output logic                      load_weight_o,
   output logic                      block_valid_o,
   output logic                      act_zero_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [CNT_W-1:0]          blocks_computed_o,
   output logic [CNT_W-1:0]          blocks_skipped_o
);

   localparam int unsigned RowW = $clog2(N_ROWS);
   localparam logic [CNT_W-1:0] LoadLast  = CNT_W'(N_ROWS - 1);
   localparam logic [CNT_W-1:0] DrainLast = CNT_W'(N_ROWS + N_COLS - 2);
   localparam logic [CNT_W-1:0] FlushLast = CNT_W'(RD_LAT - 1);

   typedef enum logic [2:0] {StIdle, StFetch, StLoadW, StStream, StDrain, StFlush} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   comp_q, comp_d;
   logic [CNT_W-1:0]   skip_q, skip_d;
   logic               done_q, done_d;
   logic [RD_LAT-1:0]  lw_q, lw_d, bv_q, bv_d, az_q, az_d;
   logic               drain_en;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      last_d  = last_q;
      comp_d  = comp_q;
      skip_d  = skip_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StFetch;
               len_d   = (cfg_stream_len_i == '0) ? CNT_W'(1) : cfg_stream_len_i;
               comp_d  = '0;
               skip_d  = '0;
               cnt_d   = '0;
            end
         end
         StFetch: begin
            if (meta_valid_i) begin
               last_d = meta_last_i;
               cnt_d  = '0;
               if (meta_zero_i) begin
                  skip_d = (skip_q == '1) ? skip_q : skip_q + CNT_W'(1);
                  if (meta_last_i) state_d = (comp_q != '0) ? StDrain : StFlush;
               end else begin
                  state_d = StLoadW;
               end
            end
         end
         StLoadW: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LoadLast) begin
               cnt_d   = '0;
               state_d = StStream;
            end
         end
         StStream: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == len_q - CNT_W'(1)) begin
               cnt_d   = '0;
               comp_d  = (comp_q == '1) ? comp_q : comp_q + CNT_W'(1);
               state_d = last_q ? StDrain : StFetch;
            end
         end
         StDrain: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == DrainLast) begin
               cnt_d   = '0;
               state_d = StFlush;
            end
         end
         StFlush: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == FlushLast) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Abort outranks everything, including a same-cycle start; counters keep their values.
      if (abort_i) begin
         state_d = StIdle;
         cnt_d   = '0;
         comp_d  = comp_q;
         skip_d  = skip_q;
         done_d  = 1'b0;
      end
   end

   assign meta_ready_o = (state_q == StFetch);
   assign wgt_rd_en_o  = (state_q == StLoadW);
   assign wgt_rd_row_o = (state_q == StLoadW) ? cnt_q[RowW-1:0] : '0;
   assign act_rd_en_o  = (state_q == StStream);
   assign drain_en     = (state_q == StDrain);
   assign busy_o       = (state_q != StIdle);

   // Shift registers match the buffer read latency so array controls line up with data.
   always_comb begin
      lw_d = RD_LAT'({lw_q, wgt_rd_en_o});
      bv_d = RD_LAT'({bv_q, act_rd_en_o | drain_en});
      az_d = RD_LAT'({az_q, drain_en});
      if (abort_i) begin
         lw_d = '0;
         bv_d = '0;
         az_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         len_q   <= '0;
         last_q  <= 1'b0;
         comp_q  <= '0;
         skip_q  <= '0;
         done_q  <= 1'b0;
         lw_q    <= '0;
         bv_q    <= '0;
         az_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         last_q  <= last_d;
         comp_q  <= comp_d;
         skip_q  <= skip_d;
         done_q  <= done_d;
         lw_q    <= lw_d;
         bv_q    <= bv_d;
         az_q    <= az_d;
      end
   end

   assign load_weight_o     = lw_q[RD_LAT-1];
   assign block_valid_o     = bv_q[RD_LAT-1];
   assign act_zero_o        = az_q[RD_LAT-1];
   assign done_o            = done_q;
   assign blocks_computed_o = comp_q;
   assign blocks_skipped_o  = skip_q;

endmodule

// File: tb/tb_bsr_block_scheduler.sv
// Directed bench for bsr_block_scheduler (N_ROWS=N_COLS=4, RD_LAT=1); per-cycle output traces
// are compared against hand-derived cycle masks.
module tb_bsr_block_scheduler;

   localparam int unsigned NR = 4;
   localparam int unsigned NC = 4;
   localparam int unsigned RL = 1;
   localparam int unsigned CW = 16;

   logic          clk_i, rst_ni, start_i, abort_i;
   logic [CW-1:0] cfg_stream_len_i;
   logic          meta_valid_i, meta_ready_o, meta_zero_i, meta_last_i;
   logic          wgt_rd_en_o, act_rd_en_o, load_weight_o, block_valid_o, act_zero_o;
   logic [1:0]    wgt_rd_row_o;
   logic          busy_o, done_o;
   logic [CW-1:0] blocks_computed_o, blocks_skipped_o;

   bsr_block_scheduler #(.N_ROWS(NR), .N_COLS(NC), .RD_LAT(RL), .CNT_W(CW)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .start_i          (start_i),
      .abort_i          (abort_i),
      .cfg_stream_len_i (cfg_stream_len_i),
      .meta_valid_i     (meta_valid_i),
      .meta_ready_o     (meta_ready_o),
      .meta_zero_i      (meta_zero_i),
      .meta_last_i      (meta_last_i),
      .wgt_rd_en_o      (wgt_rd_en_o),
      .wgt_rd_row_o     (wgt_rd_row_o),
      .act_rd_en_o      (act_rd_en_o),
      .load_weight_o    (load_weight_o),
      .block_valid_o    (block_valid_o),
      .act_zero_o       (act_zero_o),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .blocks_computed_o(blocks_computed_o),
      .blocks_skipped_o (blocks_skipped_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // Scenario controls
   int          cyc, desc_idx, desc_n, abort_cyc, extra_start_cyc, valid_from;
   logic [7:0]  d_zero, d_last;
   logic [CW-1:0] cfg0, cfg_late;

   // Per-cycle traces, bit k = value seen during cycle k
   logic [63:0] tr_mr, tr_wgt, tr_act, tr_lw, tr_bv, tr_az, tr_done, tr_busy;
   logic [1:0]  row_tr [64];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic drive_inputs();
      start_i          = (cyc == 0) || (cyc == extra_start_cyc);
      abort_i          = (cyc == abort_cyc);
      cfg_stream_len_i = (cyc == 0) ? cfg0 : cfg_late;
      meta_valid_i     = (desc_idx < desc_n) && (cyc >= valid_from);
      meta_zero_i      = (desc_idx < desc_n) ? d_zero[desc_idx] : 1'b0;
      meta_last_i      = (desc_idx < desc_n) ? d_last[desc_idx] : 1'b0;
   endtask

   task automatic step();
      logic hs;
      @(negedge clk_i);
      if (cyc < 64) begin
         tr_mr[cyc]   = meta_ready_o;
         tr_wgt[cyc]  = wgt_rd_en_o;
         tr_act[cyc]  = act_rd_en_o;
         tr_lw[cyc]   = load_weight_o;
         tr_bv[cyc]   = block_valid_o;
         tr_az[cyc]   = act_zero_o;
         tr_done[cyc] = done_o;
         tr_busy[cyc] = busy_o;
         row_tr[cyc]  = wgt_rd_row_o;
      end
      hs = meta_valid_i && meta_ready_o;
      @(posedge clk_i);
      #1;
      cyc++;
      if (hs) desc_idx++;
      drive_inputs();
   endtask

   task automatic run_tile(input int ncyc);
      cyc = 0;
      desc_idx = 0;
      {tr_mr, tr_wgt, tr_act, tr_lw, tr_bv, tr_az, tr_done, tr_busy} = '0;
      drive_inputs();
      for (int i = 0; i < ncyc; i++) step();
   endtask

   task automatic setup(input logic [CW-1:0] len, input int n);
      cfg0 = len;
      cfg_late = len;
      desc_n = n;
      abort_cyc = -1;
      extra_start_cyc = -1;
      valid_from = 0;
      d_zero = '0;
      d_last = '0;
   endtask

   initial begin
      rst_ni = 1'b0;
      {start_i, abort_i, meta_valid_i, meta_zero_i, meta_last_i} = '0;
      cfg_stream_len_i = '0;
      cyc = 0;
      desc_idx = 0;
      repeat (3) @(posedge clk_i);
      #1;
      check_eq("rst_ctrl", 64'({busy_o, done_o, meta_ready_o, wgt_rd_en_o, act_rd_en_o}), 64'd0);
      check_eq("rst_array", 64'({load_weight_o, block_valid_o, act_zero_o}), 64'd0);
      check_eq("rst_cnt", 64'({blocks_computed_o, blocks_skipped_o}), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // 1: single non-zero last block, len=3
      setup(16'd3, 1);
      d_last[0] = 1'b1;
      run_tile(20);
      check_eq("s1_ready", tr_mr, rng(1, 1));
      check_eq("s1_wgt_en", tr_wgt, rng(2, 5));
      check_eq("s1_rows", 64'({row_tr[5], row_tr[4], row_tr[3], row_tr[2]}), 64'he4);
      check_eq("s1_load_w", tr_lw, rng(3, 6));
      check_eq("s1_act_en", tr_act, rng(6, 8));
      check_eq("s1_blk_vld", tr_bv, rng(7, 16));
      check_eq("s1_act_zero", tr_az, rng(10, 16));
      check_eq("s1_done", tr_done, rng(17, 17));
      check_eq("s1_busy", tr_busy, rng(1, 16));
      check_eq("s1_computed", 64'(blocks_computed_o), 64'd1);
      check_eq("s1_skipped", 64'(blocks_skipped_o), 64'd0);

      // 2: zero, non-zero, zero+last back-to-back, len=2
      setup(16'd2, 3);
      d_zero = 8'b101;
      d_last = 8'b100;
      run_tile(22);
      check_eq("s2_load_w", tr_lw, rng(4, 7));
      check_eq("s2_blk_vld", tr_bv, rng(8, 9) | rng(11, 17));
      check_eq("s2_act_zero", tr_az, rng(11, 17));
      check_eq("s2_done", tr_done, rng(18, 18));
      check_eq("s2_computed", 64'(blocks_computed_o), 64'd1);
      check_eq("s2_skipped", 64'(blocks_skipped_o), 64'd2);

      // 3: all-zero tile of three descriptors
      setup(16'd2, 3);
      d_zero = 8'b111;
      d_last = 8'b100;
      run_tile(8);
      check_eq("s3_ready", tr_mr, rng(1, 3));
      check_eq("s3_array", tr_lw | tr_bv | tr_az, 64'd0);
      check_eq("s3_done", tr_done, rng(5, 5));
      check_eq("s3_skipped", 64'(blocks_skipped_o), 64'd3);
      check_eq("s3_computed", 64'(blocks_computed_o), 64'd0);

      // 4: two non-zero blocks, cfg_stream_len=0 acts as 1
      setup(16'd0, 2);
      d_last = 8'b10;
      run_tile(24);
      check_eq("s4_act_en", tr_act, rng(6, 6) | rng(12, 12));
      check_eq("s4_load_w", tr_lw, rng(3, 6) | rng(9, 12));
      check_eq("s4_blk_vld", tr_bv, rng(7, 7) | rng(13, 20));
      check_eq("s4_overlap", tr_lw & tr_bv, 64'd0);
      check_eq("s4_done", tr_done, rng(21, 21));
      check_eq("s4_computed", 64'(blocks_computed_o), 64'd2);

      // 5: abort in the 2nd LOAD_W cycle, then a clean tile
      setup(16'd1, 2);
      d_zero = 8'b01;
      abort_cyc = 4;
      run_tile(10);
      check_eq("s5_load_w", tr_lw, rng(4, 4));
      check_eq("s5_busy", tr_busy, rng(1, 4));
      check_eq("s5_done", tr_done, 64'd0);
      check_eq("s5_skip_hold", 64'(blocks_skipped_o), 64'd1);
      setup(16'd1, 1);
      d_last[0] = 1'b1;
      run_tile(18);
      check_eq("s5b_load_w", tr_lw, rng(3, 6));
      check_eq("s5b_done", tr_done, rng(15, 15));
      check_eq("s5b_counts", 64'({blocks_computed_o, blocks_skipped_o}), {32'd0, 16'd1, 16'd0});

      // 6: stray start while busy plus a 20-cycle descriptor stall
      setup(16'd2, 1);
      d_last[0] = 1'b1;
      cfg_late = 16'd5;
      extra_start_cyc = 3;
      valid_from = 21;
      run_tile(40);
      check_eq("s6_busy", tr_busy, rng(1, 35));
      check_eq("s6_load_w", tr_lw, rng(23, 26));
      check_eq("s6_act_en", tr_act, rng(26, 27));
      check_eq("s6_blk_vld", tr_bv, rng(27, 35));
      check_eq("s6_done", tr_done, rng(36, 36));
      check_eq("s6_computed", 64'(blocks_computed_o), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
